node_feeder: RTL

Packs serial 8-bit pixel/weight byte pairs into the 128-bit `p`/`w` lane vectors and 20-bit bias consumed by the neuron node datapath (`nodeFunc` → `mac_acc` → `sigmoid_func`). It sits between the image/weight memories and one neuron. It streams one neuron's full input vector as `CHUNKS` 16-lane words, each under a valid/ready handshake, with first/last markers so the accumulator can seed bias and close the sum.

---
 rtl/node_feeder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/node_feeder.sv
`default_nettype none
// ============================================================================
// node_feeder : packs serial pixel/weight byte pairs into LANES-wide p/w words
//               plus a per-neuron bias for the neuron node datapath.
// Option      : NODE_FEEDER_PINGPONG_EN adds a second lane buffer so filling
//               overlaps presentation.
// Revision    : 1.0
// ============================================================================
module node_feeder #(
    parameter int LANES  = 16,
    parameter int CHUNKS = 49
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [19:0]          bias_in_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [7:0]           in_pix_i,
    input  logic [7:0]           in_wgt_i,
    output logic [8*LANES-1:0]   p_o,
    output logic [8*LANES-1:0]   w_o,
    output logic [19:0]          b_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_first_o,
    output logic                 out_last_o,
    output logic                 done_o,
    output logic                 busy_o
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(CHUNKS + 1);
    localparam int DW = 8 * LANES;
    localparam logic [LW-1:0] LANE_LAST  = LW'(LANES - 1);
    localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [LW-1:0]   lane_q;
    logic [CW-1:0]   out_chunk_q;
    logic [DW-1:0]   fill_p_q, fill_w_q;
    logic [DW-1:0]   fill_p_d, fill_w_d;
    logic [19:0]     b_q;
    logic            in_ready_q, out_valid_q, out_first_q, out_last_q;
    logic            done_q, busy_q;

    logic in_hs, out_hs, word_cmp, slot_free;
    logic load_new, load_pend, out_valid_d, in_ready_d;

    assign in_hs     = in_valid_i & in_ready_q;
    assign out_hs    = out_valid_q & out_ready_i;
    assign word_cmp  = in_hs & (lane_q == LANE_LAST);
    assign slot_free = ~out_valid_q | out_hs;
    assign load_new  = word_cmp & slot_free;

`ifdef NODE_FEEDER_PINGPONG_EN
    logic [CW-1:0] fill_chunk_q;
    logic [DW-1:0] pres_p_q, pres_w_q;
    logic          pend_q, all_filled_q;
    logic          pend_d, all_filled_d;

    // pend_q: the fill buffer holds a finished word waiting for the output slot
    assign load_pend    = pend_q & out_hs;
    assign pend_d       = (pend_q & ~out_hs) | (word_cmp & ~slot_free);
    assign all_filled_d = all_filled_q | (word_cmp & (fill_chunk_q == CHUNK_LAST));
    assign out_valid_d  = load_new | load_pend | (out_valid_q & ~out_hs);
    assign in_ready_d   = ~pend_d & ~all_filled_d;
    assign p_o          = pres_p_q;
    assign w_o          = pres_w_q;
`else
    assign load_pend    = 1'b0;
    assign out_valid_d  = load_new | (out_valid_q & ~out_hs);
    assign in_ready_d   = ~out_valid_d;
    assign p_o          = fill_p_q;
    assign w_o          = fill_w_q;
`endif

    always_comb begin
        fill_p_d = fill_p_q;
        fill_w_d = fill_w_q;
        if (in_hs) begin
            fill_p_d[{lane_q, 3'b000} +: 8] = in_pix_i;
            fill_w_d[{lane_q, 3'b000} +: 8] = in_wgt_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            out_chunk_q  <= '0;
            fill_p_q     <= '0;
            fill_w_q     <= '0;
            b_q          <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef NODE_FEEDER_PINGPONG_EN
            fill_chunk_q <= '0;
            pres_p_q     <= '0;
            pres_w_q     <= '0;
            pend_q       <= 1'b0;
            all_filled_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_FILL;
                        b_q          <= bias_in_i;
                        lane_q       <= '0;
                        out_chunk_q  <= '0;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
`ifdef NODE_FEEDER_PINGPONG_EN
                        fill_chunk_q <= '0;
                        pend_q       <= 1'b0;
                        all_filled_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (in_hs) begin
                        fill_p_q <= fill_p_d;
                        fill_w_q <= fill_w_d;
                        lane_q   <= (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
                    end
                    if (out_hs && out_last_q) begin
                        state_q     <= S_IDLE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_first_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end else begin
                        state_q     <= in_ready_d ? S_FILL : S_HOLD;
                        in_ready_q  <= in_ready_d;
                        out_valid_q <= out_valid_d;
                        // out_chunk_q counts words handed to the output slot
                        if (load_new || load_pend) begin
                            out_first_q <= (out_chunk_q == '0);
                            out_last_q  <= (out_chunk_q == CHUNK_LAST);
                            out_chunk_q <= out_chunk_q + 1'b1;
                        end else if (out_hs) begin
                            out_first_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
`ifdef NODE_FEEDER_PINGPONG_EN
                        pend_q       <= pend_d;
                        all_filled_q <= all_filled_d;
                        if (word_cmp)
                            fill_chunk_q <= fill_chunk_q + 1'b1;
                        if (load_new) begin
                            pres_p_q <= fill_p_d;
                            pres_w_q <= fill_w_d;
                        end else if (load_pend) begin
                            pres_p_q <= fill_p_q;
                            pres_w_q <= fill_w_q;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign b_o         = b_q;
    assign out_valid_o = out_valid_q;
    assign out_first_o = out_first_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire
